// File: rtl/shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_seq
// Purpose  : Iterative 32-bit shifter for the multicycle MIPS datapath. It
//            moves the operand one bit position per clock and reports
//            completion with a start/busy/done handshake. The result is held
//            until the next accepted start.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous, active-high reset
//            start    - request, sampled only in IDLE
//            op       - 00 SLL, 01 SRL, 10 SRA, 11 ROR or pass-through
//            shamt    - 5-bit shift amount
//            in_data  - 32-bit operand
//            busy     - high while shifting
//            done     - one-cycle completion pulse
//            out      - 32-bit result register
// Config   : SHIFT_ROR_EN defined   -> op 11 is rotate right
//            SHIFT_ROR_EN undefined -> op 11 passes in_data straight through
// Revision : 1.0 - initial release
// ============================================================================
module shift_unit_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] in_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] out_q,   out_d;
  logic [1:0]  op_q,    op_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        op_active;

  // Op 11 only iterates when rotate is built in; otherwise it completes
  // immediately as a pass-through.
  always_comb begin
`ifdef SHIFT_ROR_EN
    op_active = 1'b1;
`else
    op_active = (op != OP_ROR);
`endif
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    op_d    = op_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          out_d = in_data;
          op_d  = op;
          cnt_d = shamt;
          if ((shamt != 5'd0) && op_active) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_SHIFT: begin
        case (op_q)
          OP_SLL:  out_d = {out_q[30:0], 1'b0};
          OP_SRL:  out_d = {1'b0, out_q[31:1]};
          OP_SRA:  out_d = {out_q[31], out_q[31:1]};
          default: begin
`ifdef SHIFT_ROR_EN
            out_d = {out_q[0], out_q[31:1]};
`else
            out_d = out_q;
`endif
          end
        endcase
        cnt_d = cnt_q - 5'd1;
        // Last shift happens on this edge when one step remains.
        if (cnt_q == 5'd1) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= 32'h0000_0000;
      op_q    <= OP_SLL;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
`default_nettype wire
